// File: rtl/rsa_pkg.sv
// rsa_pkg: shared datapath width, FSM state encoding and latency for CRT recombination
package rsa_pkg;
  localparam int CRT_WIDTH = 512;
  localparam int CRT_LATENCY = 3 * CRT_WIDTH + 2;
  typedef enum logic [2:0] {IDLE, REDQ, SUB, MODMUL, MUL, ADD} crt_state_e;
  function automatic int crt_latency(input int w);
    return 3 * w + 2;
  endfunction
endpackage

// File: rtl/crt_recombine_mod_add_sub.sv
// crt_recombine_mod_add_sub: reduces x < 2p to x mod p with one subtract-and-select
module crt_recombine_mod_add_sub
  import rsa_pkg::*;
#(
  parameter int WIDTH = CRT_WIDTH
) (
  input  logic [WIDTH:0]   x,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] y
);
  logic [WIDTH+1:0] diff;
  assign diff = {1'b0, x} - {2'b00, p};
  assign y = diff[WIDTH+1] ? x[WIDTH-1:0] : diff[WIDTH-1:0];
endmodule

// File: rtl/crt_recombine.sv
// crt_recombine: bit-serial Garner recombination m = mq + q*(((mp-mq) mod p)*qinv mod p); CRT_RANGE_CHECK_EN enables input range checking
module crt_recombine
  import rsa_pkg::*;
#(
  parameter int WIDTH = CRT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   p,
  input  logic [WIDTH-1:0]   q,
  input  logic [WIDTH-1:0]   qinv,
  input  logic [WIDTH-1:0]   mp,
  input  logic [WIDTH-1:0]   mq,
  output logic [2*WIDTH-1:0] m,
  output logic               busy,
  output logic               done,
  output logic               err
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  crt_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] p_q, q_q, qinv_q, mp_q, mq_q;
  logic [WIDTH-1:0] r_q, r_d, d_q, d_d, h_q, h_d, ya, yb;
  logic [2*WIDTH-1:0] a_q, a_d, m_q, m_d;
  logic [WIDTH:0] xa, xb;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic go, bad, wrap, serial;
`ifdef CRT_RANGE_CHECK_EN
  assign bad = p == '0 || !p[0] || mp >= p || qinv >= p;
`else
  assign bad = 1'b0;
`endif
  assign go = state_q == IDLE && start;
  assign wrap = cnt_q == '0;
  assign serial = state_q == REDQ || state_q == MODMUL || state_q == MUL;
  // REDQ folds in one mq bit, SUB forms mp + p - r (always in [1, 2p)), MODMUL doubles h
  assign xa = state_q == REDQ ? {r_q, mq_q[cnt_q]} :
              state_q == MODMUL ? {h_q, 1'b0} :
              {1'b0, mp_q} + {1'b0, p_q} - {1'b0, r_q};
  assign xb = {1'b0, ya} + (qinv_q[cnt_q] ? {1'b0, d_q} : '0);
  crt_recombine_mod_add_sub #(.WIDTH(WIDTH)) u_red_a (.x(xa), .p(p_q), .y(ya));
  crt_recombine_mod_add_sub #(.WIDTH(WIDTH)) u_red_b (.x(xb), .p(p_q), .y(yb));
  // next-state and datapath update for each phase of the recombination
  always_comb begin
    state_d = state_q;
    cnt_d = serial && !wrap ? cnt_q - CW'(1) : LAST;
    r_d = r_q;
    d_d = d_q;
    h_d = h_q;
    a_d = a_q;
    m_d = m_q;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        done_d = bad;
        err_d = bad;
        busy_d = !bad;
        state_d = bad ? IDLE : REDQ;
        r_d = '0;
        d_d = '0;
        h_d = '0;
        a_d = '0;
      end
      REDQ: begin
        r_d = ya;
        state_d = wrap ? SUB : REDQ;
      end
      SUB: begin
        d_d = ya;
        state_d = MODMUL;
      end
      MODMUL: begin
        h_d = yb;
        state_d = wrap ? MUL : MODMUL;
      end
      MUL: begin
        a_d = {a_q[2*WIDTH-2:0], 1'b0} + (h_q[cnt_q] ? {{WIDTH{1'b0}}, q_q} : '0);
        state_d = wrap ? ADD : MUL;
      end
      ADD: begin
        m_d = a_q + {{WIDTH{1'b0}}, mq_q};
        done_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // operands are frozen at the accepted start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
      q_q <= '0;
      qinv_q <= '0;
      mp_q <= '0;
      mq_q <= '0;
    end else if (go) begin
      p_q <= p;
      q_q <= q;
      qinv_q <= qinv;
      mp_q <= mp;
      mq_q <= mq;
    end
  end
  // state, counters, accumulators and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      r_q <= '0;
      d_q <= '0;
      h_q <= '0;
      a_q <= '0;
      m_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      r_q <= r_d;
      d_q <= d_d;
      h_q <= h_d;
      a_q <= a_d;
      m_q <= m_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign m = m_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
endmodule

// File: tb/tb_crt_recombine.sv
// tb_crt_recombine: directed checks of CRT recombination results, latency, reset abort and start filtering
module tb_crt_recombine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [7:0] p = '0, q = '0, qinv = '0, mp = '0, mq = '0;
  logic [15:0] m;
  logic busy, done, err;
  int checks = 0;
  int passes = 0;
  int cyc, extra;

  crt_recombine #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .p(p), .q(q), .qinv(qinv),
    .mp(mp), .mq(mq), .m(m), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic launch(input logic [7:0] pp, qq, qi, mpp, mqq);
    @(negedge clk);
    p = pp; q = qq; qinv = qi; mp = mpp; mq = mqq; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int c);
    c = 0;
    while (done !== 1'b1 && c < 60) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic count_done(input int n, output int k);
    k = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done === 1'b1) k++;
    end
  endtask

  task automatic run_vec(input string tag, input logic [7:0] pp, qq, qi, mpp, mqq, input logic [15:0] exp_m);
    int c;
    launch(pp, qq, qi, mpp, mqq);
    check({tag, "_busy"}, busy, 1);
    wait_done(c);
    check({tag, "_latency"}, c, 26);
    check({tag, "_m"}, m, exp_m);
    check({tag, "_err"}, err, 0);
    check({tag, "_busy_drop"}, busy, 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    #1;
    check("reset_m", m, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_vec("v1", 8'd11, 8'd7, 8'd8, 8'd8, 8'd2, 16'd30);
    run_vec("v2_wrap", 8'd7, 8'd11, 8'd2, 8'd4, 8'd5, 16'd60);
    run_vec("v3_redq", 8'd5, 8'd13, 8'd2, 8'd0, 8'd11, 16'd50);
    run_vec("h0_small", 8'd11, 8'd7, 8'd8, 8'd2, 8'd2, 16'd2);
    run_vec("h0_big", 8'd11, 8'd17, 8'd2, 8'd2, 8'd13, 16'd13);
    // abort inside MODMUL: no done afterwards, then a clean rerun
    launch(8'd11, 8'd7, 8'd8, 8'd8, 8'd2);
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_m", m, 0);
    @(negedge clk);
    rst_n = 1'b1;
    count_done(40, extra);
    check("abort_no_done", extra, 0);
    run_vec("after_abort", 8'd11, 8'd7, 8'd8, 8'd8, 8'd2, 16'd30);
    // second start while busy must be ignored, inputs changed after capture too
    launch(8'd7, 8'd11, 8'd2, 8'd4, 8'd5);
    repeat (5) @(negedge clk);
    p = 8'd5; q = 8'd13; mp = 8'd0; mq = 8'd11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    check("ignore_latency", cyc + 6, 26);
    check("ignore_m", m, 60);
    count_done(40, extra);
    check("ignore_single_done", extra, 0);
`ifdef CRT_RANGE_CHECK_EN
    launch(8'd11, 8'd7, 8'd8, 8'd12, 8'd2);
    check("rc_mp_done", done, 1);
    check("rc_mp_err", err, 1);
    check("rc_mp_m", m, 60);
    check("rc_mp_busy", busy, 0);
    @(negedge clk);
    check("rc_mp_err_pulse", err, 0);
    launch(8'd10, 8'd7, 8'd3, 8'd8, 8'd2);
    check("rc_even_done", done, 1);
    check("rc_even_err", err, 1);
    check("rc_even_m", m, 60);
    run_vec("rc_clean", 8'd11, 8'd7, 8'd8, 8'd8, 8'd2, 16'd30);
`else
    launch(8'd11, 8'd7, 8'd8, 8'd12, 8'd2);
    check("norc_busy", busy, 1);
    check("norc_err_early", err, 0);
    wait_done(cyc);
    check("norc_latency", cyc, 26);
    check("norc_err", err, 0);
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
